// File: rtl/ddr_if_2to5_rx.sv
// Two-lane 10:1 word aligner and 4x5 sample repacker for the receive side of the 5-to-2 DDR link.
// Optional per-lane bad-frame counters are built when DDR_IF_RX_ERRCNT_EN is defined.
module ddr_if_2to5_rx #(
    parameter int unsigned      WIDTH       = 14,
    parameter logic [WIDTH-1:0] TRAIN_MARK  = 14'h3F00,
    parameter logic [WIDTH-1:0] TRAIN_FILL  = 14'h0055,
    parameter int unsigned      LOCK_FRAMES = 4,
    parameter int unsigned      MISS_LIMIT  = 3
) (
    input  logic                          clk80_i,
    input  logic                          reset_n_i,
    input  logic [1:0][9:0][WIDTH-1:0]    rx_data_i,
    input  logic                          train_en_i,
    input  logic                          err_clr_i,
    output logic [3:0][4:0][WIDTH-1:0]    data_out_o,
    output logic                          data_valid_o,
    output logic [1:0]                    lane_locked_o,
    output logic [1:0][3:0]               lane_offset_o,
    output logic [1:0][15:0]              err_count_o
);

    localparam logic [3:0] LockFrames = 4'(LOCK_FRAMES);
    localparam logic [3:0] MissLimit  = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {
        StSearch,
        StVerify,
        StLocked
    } state_e;

    logic [1:0][9:0][WIDTH-1:0] frame_all;
    logic [1:0]                 lock_nxt;
    logic [3:0][4:0][WIDTH-1:0] data_out_d, data_out_q;
    logic                       data_valid_q;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [9:0][WIDTH-1:0]  cur_q, prev_q;
        logic [19:0][WIDTH-1:0] win;
        logic [9:0]             match;
        logic [3:0]             hit_cnt, hit_idx;
        logic                   cur_ok;
        logic                   err_inc;
        logic [9:0][WIDTH-1:0]  frame;
        state_e                 state_q, state_d;
        logic [3:0]             offset_q, offset_d;
        logic [3:0]             good_q, good_d;
        logic [3:0]             miss_q, miss_d;

        always_ff @(posedge clk80_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cur_q  <= '0;
                prev_q <= '0;
            end else begin
                cur_q  <= rx_data_i[l];
                prev_q <= cur_q;
            end
        end

        // win[0..9] is the older cycle, so offset j selects words j..j+9 in wire order
        assign win = {cur_q, prev_q};

        always_comb begin
            for (int j = 0; j < 10; j++) begin
                match[j] = (win[j] == TRAIN_MARK);
                for (int k = 1; k < 10; k++) begin
                    match[j] = match[j] & (win[j+k] == TRAIN_FILL);
                end
            end
        end

        always_comb begin
            hit_cnt = '0;
            hit_idx = '0;
            for (int j = 0; j < 10; j++) begin
                if (match[j]) begin
                    hit_cnt = hit_cnt + 4'd1;
                    hit_idx = 4'(j);
                end
            end
        end

        always_comb begin
            frame = '0;
            for (int j = 0; j < 10; j++) begin
                if (offset_q == 4'(j)) begin
                    for (int w = 0; w < 10; w++) begin
                        frame[w] = win[j+w];
                    end
                end
            end
        end

        assign cur_ok = match[offset_q];

        always_comb begin
            state_d  = state_q;
            offset_d = offset_q;
            good_d   = good_q;
            miss_d   = miss_q;
            err_inc  = 1'b0;
            if (train_en_i) begin
                unique case (state_q)
                    StSearch: begin
                        // Ambiguous windows (several candidate offsets) are ignored
                        if (hit_cnt == 4'd1) begin
                            offset_d = hit_idx;
                            good_d   = 4'd1;
                            miss_d   = '0;
                            state_d  = (LockFrames <= 4'd1) ? StLocked : StVerify;
                        end
                    end
                    StVerify: begin
                        if (cur_ok) begin
                            good_d = good_q + 4'd1;
                            if (good_d >= LockFrames) begin
                                state_d = StLocked;
                                miss_d  = '0;
                            end
                        end else begin
                            good_d  = '0;
                            state_d = StSearch;
                        end
                    end
                    StLocked: begin
                        if (cur_ok) begin
                            miss_d = '0;
                        end else begin
                            err_inc = 1'b1;
                            miss_d  = miss_q + 4'd1;
                            if (miss_d >= MissLimit) begin
                                miss_d  = '0;
                                good_d  = '0;
                                state_d = StSearch;
                            end
                        end
                    end
                    default: state_d = StSearch;
                endcase
            end
        end

        always_ff @(posedge clk80_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                state_q  <= StSearch;
                offset_q <= '0;
                good_q   <= '0;
                miss_q   <= '0;
            end else begin
                state_q  <= state_d;
                offset_q <= offset_d;
                good_q   <= good_d;
                miss_q   <= miss_d;
            end
        end

        assign frame_all[l]     = frame;
        assign lock_nxt[l]      = (state_d == StLocked);
        assign lane_locked_o[l] = (state_q == StLocked);
        assign lane_offset_o[l] = offset_q;

`ifdef DDR_IF_RX_ERRCNT_EN
        logic [15:0] err_q, err_d;

        always_comb begin
            err_d = err_q;
            if (err_clr_i) begin
                err_d = '0;
            end else if (err_inc && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end
        end

        always_ff @(posedge clk80_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                err_q <= '0;
            end else begin
                err_q <= err_d;
            end
        end

        assign err_count_o[l] = err_q;
`else
        logic unused_err;
        assign unused_err     = err_inc ^ err_clr_i;
        assign err_count_o[l] = '0;
`endif
    end

    // Flat index n = lane*10 + word lands at [n/5][n%5], undoing the transmitter's split
    always_comb begin
        data_out_d = '0;
        for (int n = 0; n < 20; n++) begin
            data_out_d[n/5][n%5] = frame_all[n/10][n%10];
        end
    end

    always_ff @(posedge clk80_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= &lock_nxt;
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;

endmodule

// File: tb/tb_ddr_if_2to5_rx.sv
// Directed bench for ddr_if_2to5_rx: lane streams with programmable word delay, a frame-level
// reference model checked every cycle, and hand-computed spot checks.
module tb_ddr_if_2to5_rx;

    localparam logic [13:0] MARK   = 14'h3F00;
    localparam logic [13:0] FILL   = 14'h0055;
    localparam int          LOCK_N = 4;
    localparam int          MISS_N = 3;
    localparam int          HUNT = 0, CONFIRM = 1, HELD = 2;
    localparam int          KT = 0, KC = 1, KB = 2, KD = 3, KR = 4;
`ifdef DDR_IF_RX_ERRCNT_EN
    localparam bit          ErrEn = 1'b1;
`else
    localparam bit          ErrEn = 1'b0;
`endif

    logic                  clk, reset_n, train_en, err_clr;
    logic [1:0][9:0][13:0] rx_data;
    logic [3:0][4:0][13:0] dout;
    logic                  valid;
    logic [1:0]            locked;
    logic [1:0][3:0]       offset;
    logic [1:0][15:0]      errc;

    ddr_if_2to5_rx u_dut (
        .clk80_i      (clk),
        .reset_n_i    (reset_n),
        .rx_data_i    (rx_data),
        .train_en_i   (train_en),
        .err_clr_i    (err_clr),
        .data_out_o   (dout),
        .data_valid_o (valid),
        .lane_locked_o(locked),
        .lane_offset_o(offset),
        .err_count_o  (errc)
    );

`ifdef DDR_IF_RX_ERRCNT_EN
    logic [3:0][4:0][13:0] s_dout;
    logic                  s_valid;
    logic [1:0]            s_locked;
    logic [1:0][3:0]       s_offset;
    logic [1:0][15:0]      s_errc;

    ddr_if_2to5_rx #(.MISS_LIMIT(15)) u_sat (
        .clk80_i      (clk),
        .reset_n_i    (reset_n),
        .rx_data_i    (rx_data),
        .train_en_i   (train_en),
        .err_clr_i    (err_clr),
        .data_out_o   (s_dout),
        .data_valid_o (s_valid),
        .lane_locked_o(s_locked),
        .lane_offset_o(s_offset),
        .err_count_o  (s_errc)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int                    m_mode[2], m_good[2], m_miss[2], m_off[2], m_err[2];
    logic [13:0]           m_cur[2][10], m_prev[2][10];
    logic [3:0][4:0][13:0] m_dout;
    logic                  m_valid;

    logic [13:0] q0[$], q1[$];

    task automatic check(input string name, input logic [279:0] act, input logic [279:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit train_at(input logic [13:0] w[20], input int j);
        bit ok = (w[j] == MARK);
        for (int k = 1; k < 10; k++) ok = ok && (w[j+k] == FILL);
        return ok;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_mode[l] = HUNT; m_good[l] = 0; m_miss[l] = 0; m_off[l] = 0; m_err[l] = 0;
            for (int i = 0; i < 10; i++) begin
                m_cur[l][i]  = '0;
                m_prev[l][i] = '0;
            end
        end
        m_dout  = '0;
        m_valid = 1'b0;
    endtask

    // One divided-clock edge: evaluate the frame window, then shift in the new words
    task automatic model_step();
        logic [13:0] w[20];
        int hits, first, n;
        bit inc;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 20; i++) w[i] = (i < 10) ? m_prev[l][i] : m_cur[l][i-10];
            for (int k = 0; k < 10; k++) begin
                n = l * 10 + k;
                m_dout[n/5][n%5] = w[m_off[l] + k];
            end
            inc = 1'b0;
            if (train_en) begin
                hits = 0; first = 0;
                for (int j = 0; j < 10; j++) begin
                    if (train_at(w, j)) begin hits++; first = j; end
                end
                if (m_mode[l] == HUNT) begin
                    if (hits == 1) begin
                        m_off[l] = first; m_good[l] = 1; m_mode[l] = CONFIRM;
                    end
                end else if (m_mode[l] == CONFIRM) begin
                    if (train_at(w, m_off[l])) begin
                        m_good[l]++;
                        if (m_good[l] == LOCK_N) begin m_mode[l] = HELD; m_miss[l] = 0; end
                    end else begin
                        m_mode[l] = HUNT; m_good[l] = 0;
                    end
                end else begin
                    if (train_at(w, m_off[l])) m_miss[l] = 0;
                    else begin
                        inc = 1'b1;
                        m_miss[l]++;
                        if (m_miss[l] == MISS_N) begin
                            m_mode[l] = HUNT; m_miss[l] = 0; m_good[l] = 0;
                        end
                    end
                end
            end
            if (ErrEn) begin
                if (err_clr) m_err[l] = 0;
                else if (inc && m_err[l] < 65535) m_err[l]++;
            end
            for (int i = 0; i < 10; i++) begin
                m_prev[l][i] = m_cur[l][i];
                m_cur[l][i]  = rx_data[l][i];
            end
        end
        m_valid = (m_mode[0] == HELD) && (m_mode[1] == HELD);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("data_out", dout, m_dout);
            check("data_valid", valid, m_valid);
            check("lane_locked", locked, {m_mode[1] == HELD, m_mode[0] == HELD});
            check("lane_offset", offset, {4'(m_off[1]), 4'(m_off[0])});
            check("err_count", errc, {16'(m_err[1]), 16'(m_err[0])});
        end
    end

    task automatic mk_frame(input int kind, input int l, output logic [13:0] f[10]);
        for (int w = 0; w < 10; w++) begin
            case (kind)
                KT:      f[w] = (w == 0) ? MARK : FILL;
                KC:      f[w] = 14'(l * 10 + w);
                KB:      f[w] = FILL;
                KD:      f[w] = (w == 0 || w == 5) ? MARK : FILL;
                default: f[w] = 14'($urandom);
            endcase
        end
    endtask

    task automatic set_delay(input int d0, input int d1);
        q0.delete();
        q1.delete();
        for (int i = 0; i < d0; i++) q0.push_back('0);
        for (int i = 0; i < d1; i++) q1.push_back('0);
    endtask

    // Append one frame per lane to the wire, present the next 10 words of each, clock once
    task automatic send(input int k0, input int k1, input bit ten, input bit clr);
        logic [13:0] f[10];
        mk_frame(k0, 0, f);
        for (int i = 0; i < 10; i++) q0.push_back(f[i]);
        mk_frame(k1, 1, f);
        for (int i = 0; i < 10; i++) q1.push_back(f[i]);
        for (int i = 0; i < 10; i++) begin
            rx_data[0][i] = q0.pop_front();
            rx_data[1][i] = q1.pop_front();
        end
        train_en = ten;
        err_clr  = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, dout, '0);
        check({tag, "_valid"}, valid, '0);
        check({tag, "_locked"}, locked, '0);
        check({tag, "_offset"}, offset, '0);
        check({tag, "_err"}, errc, '0);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_zero("reset_mid");
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_data  = '0;
        train_en = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        set_delay(0, 0);
        repeat (2) @(posedge clk);
        #2 check_zero("reset_init");
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // Aligned training: four good frames lock, evaluation trails the wire by two cycles
        repeat (5) send(KT, KT, 1, 0);
        check("lock_not_yet", locked, 2'b00);
        send(KT, KT, 1, 0);
        check("lock_both", locked, 2'b11);
        check("valid_both", valid, 1'b1);
        check("offset_zero", offset, 8'h00);

        // Skewed lanes, then counting samples through the repacker
        do_reset();
        set_delay(3, 7);
        repeat (6) send(KT, KT, 1, 0);
        check("offset_skew", offset, {4'd7, 4'd3});
        check("lock_skew", locked, 2'b11);
        repeat (4) send(KC, KC, 0, 0);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 5; c++) begin
                check($sformatf("count_s%0d_c%0d", s, c), dout[s][c], 14'(s * 5 + c));
            end
        end

        // Two marks per frame: never leaves SEARCH
        do_reset();
        set_delay(0, 0);
        repeat (8) send(KD, KD, 1, 0);
        check("dbl_mark_lock", locked, 2'b00);
        check("dbl_mark_off", offset, 8'h00);

        // Lane 1 loses three frames while lane 0 stays locked
        do_reset();
        set_delay(0, 0);
        repeat (6) send(KT, KT, 1, 0);
        repeat (3) send(KT, KB, 1, 0);
        send(KT, KT, 1, 0);
        check("two_miss_hold", locked, 2'b11);
        send(KT, KT, 1, 0);
        check("three_miss_drop", locked, 2'b01);
        check("drop_valid", valid, 1'b0);
        check("drop_err", errc[1], ErrEn ? 16'd3 : 16'd0);
        repeat (5) send(KT, KT, 1, 0);
        check("relock", locked, 2'b11);
        send(KT, KT, 1, 1);
        check("err_clr", errc, '0);
        repeat (2) send(KT, KB, 1, 0);
        repeat (4) send(KT, KT, 1, 0);
        check("two_bad_lock", locked, 2'b11);
        check("two_bad_err", errc[1], ErrEn ? 16'd2 : 16'd0);

        // Training off: random traffic cannot disturb lock; then reset mid-frame and relock
        do_reset();
        set_delay(0, 0);
        repeat (6) send(KT, KT, 1, 0);
        repeat (1000) send(KR, KR, 0, 0);
        check("rand_lock", locked, 2'b11);
        check("rand_err", errc, '0);
        do_reset();
        set_delay(0, 0);
        repeat (6) send(KT, KT, 1, 0);
        check("post_reset_lock", locked, 2'b11);

`ifdef DDR_IF_RX_ERRCNT_EN
        // Wide miss limit instance: 14 misses per 15 frames keeps it locked while counting
        for (int r = 0; r < 4682; r++) begin
            repeat (14) send(KT, KB, 1, 0);
            send(KT, KT, 1, 0);
        end
        repeat (3) send(KT, KB, 1, 0);
        check("sat_value", s_errc[1], 16'hFFFF);
        check("sat_locked", s_locked[1], 1'b1);
        send(KT, KB, 1, 1);
        check("sat_clr_wins", s_errc[1], 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_if_2to5_rx.md
# ddr_if_2to5_rx

Receive-side gearbox for the 5-to-2 DDR source-synchronous link. Takes the 10:1 deserialized words of the two 14-bit DDR lanes in the 80 MHz divided-clock domain and aligns each lane to its 10-word frame boundary using a training pattern. Re-packs the 20 aligned words into the 4-sample x 5-channel layout the transmitter demultiplexed from. Sits between the two ISERDES lane blocks and the downstream 80 MHz sample consumer.

## Interface
- WIDTH, 14, bits per word
- TRAIN_MARK, 14'h3F00, frame-start training word
- TRAIN_FILL, 14'h0055, training word for frame positions 1..9
- LOCK_FRAMES, 4, consecutive good training frames needed to lock (1..15)
- MISS_LIMIT, 3, consecutive bad training frames that drop lock (1..15)

Ports:
- clk80  in  1  divided clock; every flop on this edge
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  [1:0][9:0][WIDTH-1:0]  per-lane ISERDES words; word 0 earliest on the wire
- train_en  in  1  high while the far end sends training frames
- err_clr  in  1  synchronous clear of err_count
- data_out  out  [3:0][4:0][WIDTH-1:0]  aligned samples, [sample][channel]
- data_valid  out  1  both lanes LOCKED; data_out meaningful
- lane_locked  out  [1:0]  per-lane LOCKED state
- lane_offset  out  [1:0][3:0]  per-lane selected word offset 0..9
- err_count  out  [1:0][15:0]  per-lane bad-frame count

## Operation
- Per lane, stage 1 registers rx_data into cur; cur's previous value is held in prev. Window W[0..19] = prev[0..9], cur[0..9].
- Aligned frame at offset j = W[j..j+9].
- Match(j): W[j]==TRAIN_MARK and W[j+1..j+9] all ==TRAIN_FILL.
- Per-lane FSM, evaluated only on cycles with train_en=1; train_en=0 holds state and counters.
  - SEARCH: if exactly one j in 0..9 matches, load offset=j, good=1, go VERIFY. No match or multiple matches: stay.
  - VERIFY: Match(offset) → good+1; when good reaches LOCK_FRAMES, go LOCKED. Mismatch → SEARCH, good=0.
  - LOCKED: Match(offset) → miss=0. Mismatch → miss+1 and err_count+1. When miss reaches MISS_LIMIT, go SEARCH.
- Offset changes only on SEARCH→VERIFY. It is never altered in LOCKED.
- Packing: the aligned frame of lane l, word w, is flat index n=l*10+w, placed at data_out[n/5][n%5]. This is the inverse of the transmitter mapping.
- data_out is registered. It updates every cycle regardless of lock and uses the current offset of each lane.
- data_valid = lane_locked[0] & lane_locked[1], registered alongside data_out.
- Reset (async, any time, including mid-lock): FSMs go to SEARCH. Offset, good, miss, cur, prev, data_out, err_count, lane_locked and data_valid all go to 0.

## Timing
- Latency: a word entering on rx_data at cycle t appears on data_out at t+2 if it falls in cur at alignment, or at t+3 if it falls in prev.
- lane_locked rises on the cycle after the LOCK_FRAMES-th consecutive good frame is evaluated.
- lane_locked falls on the cycle after the MISS_LIMIT-th consecutive bad frame is evaluated.
- data_valid has the same timing as the later or earlier lane_locked edge, as appropriate.
- err_count saturates at 16'hFFFF and does not wrap.
- err_clr has priority over a simultaneous increment; the result is 0.
- Single-lane loss: that lane re-searches while the other lane stays LOCKED. data_valid stays 0 until both lanes are LOCKED.

## Configuration
- DDR_IF_RX_ERRCNT_EN defined: err_count logic is built as described.
- DDR_IF_RX_ERRCNT_EN undefined: err_count is tied to 0 and err_clr is ignored. Lock and miss behaviour is unchanged.

## Test plan
- Training frames on both lanes at offset 0, train_en=1 → lane_offset=0/0; lane_locked=2'b11 on the cycle after the 4th good frame; data_valid=1.
- Lane 0 delayed by 3 words and lane 1 by 7, training → lane_offset={7,3}; both locked. Then send counting data (channel c, sample s = 14'(s*5+c)) → data_out[s][c]==s*5+c for all 20 positions, arriving 2–3 cycles later.
- Training frame with TRAIN_MARK at two positions → no transition out of SEARCH; lane_locked=0.
- While locked with train_en=1, corrupt lane 1 for 3 frames → err_count[1]=3, lane_locked[1]=0, data_valid=0, lane 0 still locked. Corrupt for only 2 frames → lock held, err_count[1]=2.
- Lock both lanes, set train_en=0 and feed random data for 1000 cycles → lock held, err_count unchanged. Then pulse reset_n low mid-frame → all outputs 0 immediately; relock after 4 training frames.
- Force err_count to saturation via a long error run (macro defined) → holds at 16'hFFFF. err_clr together with an error → 0. With the macro undefined, err_count stays 0 throughout.
